// File: rtl/jt12_eg_pkg.sv
// Shared definitions for the envelope-generator slot engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jt12_eg_pkg;

  localparam int NUM_SLOTS = 24;
  localparam int SLOT_W    = 5;

  // One-hot envelope phases; RELEASE is the all-zero code
  localparam logic [2:0] ATTACK  = 3'b001;
  localparam logic [2:0] DECAY   = 3'b010;
  localparam logic [2:0] HOLD    = 3'b100;
  localparam logic [2:0] RELEASE = 3'b000;

  localparam logic [9:0] EG_MAX = 10'h3FF;

  // Per-slot record held in the circular store
  typedef struct packed {
    logic [2:0] state;
    logic [9:0] eg;
    logic       ssg_inv;
    logic       cnt_lsb;
    logic       kon_prev;
  } eg_slot_t;

  localparam int ENTRY_W = $bits(eg_slot_t);

  // Silent slot: released, fully attenuated, no key history
  localparam eg_slot_t SLOT_RST = '{
    state:    RELEASE,
    eg:       EG_MAX,
    ssg_inv:  1'b0,
    cnt_lsb:  1'b0,
    kon_prev: 1'b0
  };

endpackage

// File: rtl/jt12_eg_ctrl_if.sv
// Bus between the slot engine (master) and the comb stage / key source (slave).
// Latency: n/a (wires only).
// Backpressure: none; clk_en is the only stall.
interface jt12_eg_ctrl_if;

  logic                          clk_en;
  logic                          kon;
  logic [jt12_eg_pkg::SLOT_W-1:0] slot;
  logic                          zero;
  logic [14:0]                   eg_cnt;
  logic                          keyon_now;
  logic                          keyoff_now;
  logic [2:0]                    state_cur;
  logic [9:0]                    eg_cur;
  logic                          ssg_inv_cur;
  logic                          cnt_lsb_cur;
  logic [2:0]                    state_nxt;
  logic [9:0]                    eg_nxt;
  logic                          ssg_inv_nxt;
  logic                          cnt_lsb_nxt;

  modport master (
    input  clk_en, kon,
    input  state_nxt, eg_nxt, ssg_inv_nxt, cnt_lsb_nxt,
    output slot, zero, eg_cnt, keyon_now, keyoff_now,
    output state_cur, eg_cur, ssg_inv_cur, cnt_lsb_cur
  );

  modport slave (
    output clk_en, kon,
    output state_nxt, eg_nxt, ssg_inv_nxt, cnt_lsb_nxt,
    input  slot, zero, eg_cnt, keyon_now, keyoff_now,
    input  state_cur, eg_cur, ssg_inv_cur, cnt_lsb_cur
  );

endinterface

// File: rtl/jt12_eg_slot_sr.sv
// Circular store: DEPTH entries of W bits, head entry read directly, tail loaded from din.
// Latency: head visible same cycle; a written entry returns to the head DEPTH enables later.
// Backpressure: none; en low freezes every entry.
module jt12_eg_slot_sr #(
  parameter int           W       = 16,
  parameter int           DEPTH   = 24,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [DEPTH];

  // Shift toward the head; the written-back entry enters at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
    end else if (en) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= din;
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/jt12_eg_ctrl.sv
// Slot-rotation engine: per-slot envelope store, slot counter, key edges, global eg_cnt.
// Latency: current-slot values are register outputs; comb results written back on the same clk_en.
// Backpressure: none; clk_en low holds every register and output.
module jt12_eg_ctrl
  import jt12_eg_pkg::*;
#(
  parameter int EG_DIV = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  jt12_eg_ctrl_if.master bus
);

  localparam int                DIV_W     = (EG_DIV > 1) ? $clog2(EG_DIV) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(EG_DIV - 1);

  eg_slot_t          cur;
  eg_slot_t          wb;
  logic [SLOT_W-1:0] slot_q;
  logic [DIV_W-1:0]  div_q;
  logic [14:0]       eg_cnt_q;
  logic              last_slot;

  // Write-back record for the slot currently leaving the head
  always_comb begin
    wb          = SLOT_RST;
    wb.state    = bus.state_nxt;
    wb.eg       = bus.eg_nxt;
    wb.ssg_inv  = bus.ssg_inv_nxt;
    wb.cnt_lsb  = bus.cnt_lsb_nxt;
    wb.kon_prev = bus.kon;
  end

  jt12_eg_slot_sr #(
    .W       (ENTRY_W),
    .DEPTH   (NUM_SLOTS),
    .RST_VAL (SLOT_RST)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.clk_en),
    .din   (wb),
    .head  (cur)
  );

  assign last_slot = (slot_q == LAST_SLOT);

  // Slot index follows the store head around the rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (bus.clk_en) begin
      slot_q <= last_slot ? '0 : slot_q + 1'b1;
    end
  end

  // Rotation divider; eg_cnt ticks once every EG_DIV full rotations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      eg_cnt_q <= '0;
    end else if (bus.clk_en && last_slot) begin
      if (div_q == LAST_DIV) begin
        div_q    <= '0;
        eg_cnt_q <= eg_cnt_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign bus.slot        = slot_q;
  assign bus.zero        = (slot_q == '0);
  assign bus.eg_cnt      = eg_cnt_q;
  assign bus.state_cur   = cur.state;
  assign bus.eg_cur      = cur.eg;
  assign bus.ssg_inv_cur = cur.ssg_inv;
  assign bus.cnt_lsb_cur = cur.cnt_lsb;
  // Edges compare the live key level against the level last written for this slot
  assign bus.keyon_now   =  bus.kon & ~cur.kon_prev;
  assign bus.keyoff_now  = ~bus.kon &  cur.kon_prev;

endmodule

// File: tb/tb_jt12_eg_ctrl.sv
// Bench for jt12_eg_ctrl: per-slot array model, randomized comb results and key levels.
module tb_jt12_eg_ctrl;
  import jt12_eg_pkg::*;

  logic clk;
  logic rst_n;
  logic preload;
  logic chk_on;

  int checks = 0;
  int errors = 0;

  jt12_eg_ctrl_if bus ();

  jt12_eg_ctrl #(.EG_DIV(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slot-indexed arrays instead of a rotating store
  logic [2:0]  m_state [NUM_SLOTS];
  logic [9:0]  m_eg    [NUM_SLOTS];
  logic        m_ssg   [NUM_SLOTS];
  logic        m_lsb   [NUM_SLOTS];
  logic        m_kp    [NUM_SLOTS];
  int          m_slot;
  int          m_rot;
  logic [14:0] m_cnt;

  always @(posedge clk or negedge rst_n or posedge preload) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        m_state[i] = 3'b000;
        m_eg[i]    = 10'h3FF;
        m_ssg[i]   = 1'b0;
        m_lsb[i]   = 1'b0;
        m_kp[i]    = 1'b0;
      end
      m_slot = 0;
      m_rot  = 0;
      m_cnt  = 15'd0;
    end else if (preload) begin
      m_cnt = 15'h7FFF;
    end else if (bus.clk_en) begin
      m_state[m_slot] = bus.state_nxt;
      m_eg[m_slot]    = bus.eg_nxt;
      m_ssg[m_slot]   = bus.ssg_inv_nxt;
      m_lsb[m_slot]   = bus.cnt_lsb_nxt;
      m_kp[m_slot]    = bus.kon;
      if (m_slot == NUM_SLOTS - 1) begin
        m_slot = 0;
        m_rot  = m_rot + 1;
        if (m_rot == 3) begin
          m_rot = 0;
          m_cnt = m_cnt + 15'd1;
        end
      end else begin
        m_slot = m_slot + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      #2;
      if (chk_on && rst_n) begin
        chk("slot",        32'(bus.slot),        32'(m_slot));
        chk("zero",        32'(bus.zero),        32'(m_slot == 0));
        chk("eg_cnt",      32'(bus.eg_cnt),      32'(m_cnt));
        chk("state_cur",   32'(bus.state_cur),   32'(m_state[m_slot]));
        chk("eg_cur",      32'(bus.eg_cur),      32'(m_eg[m_slot]));
        chk("ssg_inv_cur", 32'(bus.ssg_inv_cur), 32'(m_ssg[m_slot]));
        chk("cnt_lsb_cur", 32'(bus.cnt_lsb_cur), 32'(m_lsb[m_slot]));
        chk("keyon_now",   32'(bus.keyon_now),   32'(bus.kon && !m_kp[m_slot]));
        chk("keyoff_now",  32'(bus.keyoff_now),  32'(!bus.kon && m_kp[m_slot]));
      end
    end
  end

  // Samples taken inside cyc for the hand-written expectations
  int         s_slot;
  logic       s_keyon, s_keyoff;
  logic [2:0] s_state;
  logic [9:0] s_eg;

  // kon_slot: -1 kon=0, -2 random, >=0 kon high only on that slot
  // nmode: 0 loop cur->nxt, 1 random nxt, 2 loop but ATTACK/0x100 on keyon at slot 5
  task automatic cyc(input logic en, input int kon_slot, input int nmode);
    @(negedge clk);
    bus.clk_en = en;
    if (kon_slot == -2)     bus.kon = 1'($urandom_range(0, 1));
    else if (kon_slot >= 0) bus.kon = (m_slot == kon_slot);
    else                    bus.kon = 1'b0;
    #1;
    bus.state_nxt   = bus.state_cur;
    bus.eg_nxt      = bus.eg_cur;
    bus.ssg_inv_nxt = bus.ssg_inv_cur;
    bus.cnt_lsb_nxt = bus.cnt_lsb_cur;
    if (nmode == 1) begin
      bus.state_nxt   = 3'($urandom_range(0, 7));
      bus.eg_nxt      = 10'($urandom_range(0, 1023));
      bus.ssg_inv_nxt = 1'($urandom_range(0, 1));
      bus.cnt_lsb_nxt = 1'($urandom_range(0, 1));
    end else if (nmode == 2 && bus.slot == 5'd5 && bus.keyon_now) begin
      bus.state_nxt = 3'b001;
      bus.eg_nxt    = 10'h100;
    end
    s_slot   = int'(bus.slot);
    s_keyon  = bus.keyon_now;
    s_keyoff = bus.keyoff_now;
    s_state  = bus.state_cur;
    s_eg     = bus.eg_cur;
  endtask

  // Let the pending enabled edge land, then stop advancing
  task automatic settle();
    @(negedge clk);
    bus.clk_en = 1'b0;
    bus.kon    = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int pulses;
  int held_slot;

  initial begin
    rst_n = 1'b0; preload = 1'b0; chk_on = 1'b0;
    bus.clk_en = 1'b0; bus.kon = 1'b0;
    bus.state_nxt = 3'b000; bus.eg_nxt = 10'h0;
    bus.ssg_inv_nxt = 1'b0; bus.cnt_lsb_nxt = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    bus.kon = 1'b1;
    #1;
    chk("rst_slot",   32'(bus.slot),       32'd0);
    chk("rst_zero",   32'(bus.zero),       32'd1);
    chk("rst_eg_cnt", 32'(bus.eg_cnt),     32'd0);
    chk("rst_state",  32'(bus.state_cur),  32'd0);
    chk("rst_eg",     32'(bus.eg_cur),     32'h3FF);
    chk("rst_keyon",  32'(bus.keyon_now),  32'd1);
    chk("rst_keyoff", 32'(bus.keyoff_now), 32'd0);
    bus.kon = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // One idle rotation: every slot released and silent, zero only on slot 0
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cyc(1'b1, -1, 0);
      chk("idle_zero",  32'(bus.zero),   32'(i == 0));
      chk("idle_eg",    32'(s_eg),       32'h3FF);
    end

    // Key-on at slot 5 only
    pulses = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cyc(1'b1, 5, 2);
      if (s_keyon) begin
        pulses++;
        chk("keyon_slot", 32'(s_slot), 32'd5);
      end
    end
    chk("keyon_pulses", 32'(pulses), 32'd1);

    // Next rotation: slot 5 holds ATTACK/0x100, key still held so no new pulse
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cyc(1'b1, 5, 0);
      if (s_slot == 5) begin
        chk("s5_state", 32'(s_state), 32'h1);
        chk("s5_eg",    32'(s_eg),    32'h100);
        chk("s5_keyon", 32'(s_keyon), 32'd0);
      end
    end
    settle();
    chk("eg_cnt_72", 32'(bus.eg_cnt), 32'd1);

    // Key released everywhere: only slot 5 reports key-off
    pulses = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cyc(1'b1, -1, 0);
      if (s_keyoff) begin
        pulses++;
        chk("keyoff_slot", 32'(s_slot), 32'd5);
      end
    end
    chk("keyoff_pulses", 32'(pulses), 32'd1);

    for (int i = 0; i < 2 * NUM_SLOTS; i++) cyc(1'b1, -1, 0);
    settle();
    chk("eg_cnt_144", 32'(bus.eg_cnt), 32'd2);

    // Freeze mid-rotation with kon and nxt churning
    for (int i = 0; i < 7; i++) cyc(1'b1, -1, 0);
    settle();
    held_slot = int'(bus.slot);
    for (int i = 0; i < 10; i++) cyc(1'b0, -2, 1);
    chk("frz_slot",   32'(bus.slot),   32'(held_slot));
    chk("frz_eg_cnt", 32'(bus.eg_cnt), 32'd2);
    for (int i = 0; i < NUM_SLOTS; i++) cyc(1'b1, -1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) cyc(($urandom_range(0, 3) != 0), -2, 1);

    // Walk to slot 13 and hit reset between clock edges
    for (int i = 0; i < 60 && bus.slot != 5'd13; i++) begin
      cyc(1'b1, -2, 1);
      settle();
    end
    chk("reach_slot13", 32'(bus.slot), 32'd13);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_slot",   32'(bus.slot),       32'd0);
    chk("arst_zero",   32'(bus.zero),       32'd1);
    chk("arst_eg_cnt", 32'(bus.eg_cnt),     32'd0);
    chk("arst_state",  32'(bus.state_cur),  32'd0);
    chk("arst_eg",     32'(bus.eg_cur),     32'h3FF);
    chk("arst_keyoff", 32'(bus.keyoff_now), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload eg_cnt at its top value; the next tick must wrap to zero
    @(negedge clk);
    force dut.eg_cnt_q = 15'h7FFF;
    preload = 1'b1;
    #1;
    preload = 1'b0;
    release dut.eg_cnt_q;
    for (int i = 0; i < 3 * NUM_SLOTS; i++) cyc(1'b1, -1, 0);
    settle();
    chk("eg_cnt_wrap", 32'(bus.eg_cnt), 32'd0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
